spn_block_decryptor: RTL



---
 rtl/spn_block_decryptor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/spn_block_decryptor.sv
// spn_block_decryptor: iterative 128-bit decryptor for the 4-bit S-box /
// bit-permutation block cipher. Forward-expands the cipher key to the last
// round key, then unwinds the rounds with the inverse key schedule.
// Optional build macro: DECRYPT_KEY_SCRUB_EN (clears key material and
// plaintext after delivery).
module spn_block_decryptor #(
  parameter int ROUNDS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEXP  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t       fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] kreg_q, kreg_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] dout_q, dout_d;
  logic         ovld_q, ovld_d;

  logic [127:0] knext;
  logic [127:0] kprev;
  logic [127:0] rnd;

  function automatic logic [127:0] rotl13(input logic [127:0] x);
    return {x[114:0], x[127:115]};
  endfunction

  function automatic logic [127:0] rotr13(input logic [127:0] x);
    return {x[12:0], x[127:13]};
  endfunction

  // Gather form of the inverse permutation; bit 127 is a fixed point.
  function automatic logic [127:0] pinv(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 127; i++) begin
      y[i] = x[(i * 32) % 127];
    end
    y[127] = x[127];
    return y;
  endfunction

  function automatic logic [3:0] sinv_nib(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'h5;
      4'h1: r = 4'hE;
      4'h2: r = 4'hF;
      4'h3: r = 4'h8;
      4'h4: r = 4'hC;
      4'h5: r = 4'h1;
      4'h6: r = 4'h2;
      4'h7: r = 4'hD;
      4'h8: r = 4'hB;
      4'h9: r = 4'h4;
      4'hA: r = 4'h6;
      4'hB: r = 4'h3;
      4'hC: r = 4'h0;
      4'hD: r = 4'h7;
      4'hE: r = 4'h9;
      default: r = 4'hA;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] sinv(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[4*i +: 4] = sinv_nib(x[4*i +: 4]);
    end
    return y;
  endfunction

  // Forward schedule step, backward schedule step and one inverse round.
  assign knext = rotl13(kreg_q) ^ {123'b0, cnt_q};
  assign kprev = rotr13(kreg_q ^ {123'b0, cnt_q});
  assign rnd   = sinv(pinv(state_q)) ^ kprev;

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == KEXP) || (fsm_q == ROUND);
  assign out_valid = ovld_q;
  assign data_out  = dout_q;

  // State register; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      kreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ovld_q  <= ovld_d;
    end
  end

  // Next-state logic: accept, expand key, unwind rounds, hold result.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovld_d  = ovld_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = data_in;
          kreg_d  = key;
          cnt_d   = '0;
          fsm_d   = KEXP;
        end
      end
      KEXP: begin
        kreg_d = knext;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          // Undo the final whitening with K_N as soon as it is known.
          state_d = state_q ^ knext;
          cnt_d   = LAST;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = rnd;
        kreg_d  = kprev;
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else begin
          dout_d = rnd;
          ovld_d = 1'b1;
          fsm_d  = DONE;
`ifdef DECRYPT_KEY_SCRUB_EN
          kreg_d = '0;
`endif
        end
      end
      default: begin
        if (out_ready) begin
          ovld_d = 1'b0;
          fsm_d  = IDLE;
`ifdef DECRYPT_KEY_SCRUB_EN
          dout_d  = '0;
          state_d = '0;
          kreg_d  = '0;
`endif
        end
      end
    endcase
  end

endmodule
